// File: rtl/ram_dma.sv
// ram_dma: sequencing initiator for an 8-bit RAM port.
// Runs FILL, COPY and SUM operations over a byte range without CPU help.
// Every RAM write strobe is framed by one cycle of stable address/data
// before and after it, because the RAM writes whenever its write input is high.
//
// Ports:
//   clock, reset       - system clock, synchronous active-high reset
//   start, op          - request and operation (00 FILL, 01 COPY, 10 SUM, 11 reserved)
//   src, dst, len      - source/fill start, copy destination, byte count 0..256
//   fill_value         - byte written by FILL
//   busy, done, error  - in progress, one-cycle completion pulse, reserved-op flag
//   result             - SUM result (modulo 256)
//   mem_address, mem_write, mem_write_data - RAM controls (registered)
//   mem_data           - RAM combinational read data
module ram_dma (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] src,
  input  logic [7:0] dst,
  input  logic [8:0] len,
  input  logic [7:0] fill_value,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] result,
  output logic [7:0] mem_address,
  input  logic [7:0] mem_data,
  output logic       mem_write,
  output logic [7:0] mem_write_data
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 9;

  localparam logic [1:0] OP_FILL = 2'b00;
  localparam logic [1:0] OP_SUM  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_FINISH
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [DW-1:0] result_q, result_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic [LW-1:0] idx_nxt;
  logic          last;

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      result_q <= result_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign idx_nxt = idx_q + LW'(1);
  assign last    = (idx_nxt == len_q);

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    result_d = result_q;
    addr_d   = addr_q;
    wr_d     = 1'b0;
    wdata_d  = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op;
          src_d    = src;
          dst_d    = dst;
          len_d    = len;
          idx_d    = '0;
          busy_d   = 1'b1;
          error_d  = 1'b0;
          result_d = '0;
          if (op == OP_RSVD) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else if (len == LW'(0)) begin
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else if (op == OP_FILL) begin
            // Fill byte rides in the write-data register for the whole run
            addr_d  = src;
            wdata_d = fill_value;
            state_d = S_SETUP;
          end else begin
            addr_d  = src;
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        if (op_q == OP_SUM) begin
          result_d = result_q + mem_data;
          if (last) begin
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            idx_d  = idx_nxt;
            addr_d = src_q + AW'(idx_nxt);
          end
        end else begin
          // COPY: the write-data register doubles as the capture register
          addr_d  = dst_q + AW'(idx_q);
          wdata_d = mem_data;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        wr_d    = 1'b1;
        state_d = S_WRITE;
      end

      S_WRITE: begin
        state_d = S_HOLD;
      end

      S_HOLD: begin
        if (last) begin
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_nxt;
          addr_d  = src_q + AW'(idx_nxt);
          state_d = (op_q == OP_FILL) ? S_SETUP : S_READ;
        end
      end

      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign result         = result_q;
  assign mem_address    = addr_q;
  assign mem_write      = wr_q;
  assign mem_write_data = wdata_q;

endmodule
